// File: rtl/reset_synchroniser.sv
// Reset bridge into the clk domain: assertion is passed through immediately via the flop set path,
// and deassertion is released only after STAGES clk rising edges.
module reset_synchroniser #(
    parameter bit          INPUT_POLARITY  = 1'b1,
    parameter bit          OUTPUT_POLARITY = 1'b1,
    parameter int unsigned STAGES          = 2
) (
    input  logic clk,
    input  logic async_reset_i,
    output logic sync_reset_o
);

    if (STAGES < 2) begin : g_bad_stages
        $error("reset_synchroniser: STAGES must be at least 2");
    end

    logic w_rst_in;

    // A stage value of 1 means "in reset", whatever the port polarities are.
    // The declaration value sets the power-up state, so the output starts asserted.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_stage = '1;

    assign w_rst_in = (async_reset_i == INPUT_POLARITY);

    always_ff @(posedge clk or posedge w_rst_in) begin
        if (w_rst_in) begin
            r_stage <= '1;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], 1'b0};
        end
    end

    // The polarity is a constant, so the output stays a direct flop output.
    assign sync_reset_o = OUTPUT_POLARITY ? r_stage[STAGES-1] : ~r_stage[STAGES-1];

endmodule

// File: tb/tb_reset_synchroniser.sv
// Directed bench for reset_synchroniser: one instance per scenario, all checked on a shared
// absolute timeline, with each sample taken away from the clk edges.
`timescale 1ns / 1ps

module tb_reset_synchroniser;

    logic clk = 1'b0;
    logic in_a, in_b, in_c, in_d, in_e, in_f, in_g;
    logic out_a, out_b, out_c, out_d, out_e, out_f, out_g;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // a..e: active-low in, active-high out, 2 stages
    reset_synchroniser #(.INPUT_POLARITY(1'b0), .OUTPUT_POLARITY(1'b1), .STAGES(2)) u_dut_a (
        .clk(clk), .async_reset_i(in_a), .sync_reset_o(out_a));
    reset_synchroniser #(.INPUT_POLARITY(1'b0), .OUTPUT_POLARITY(1'b1), .STAGES(2)) u_dut_b (
        .clk(clk), .async_reset_i(in_b), .sync_reset_o(out_b));
    reset_synchroniser #(.INPUT_POLARITY(1'b0), .OUTPUT_POLARITY(1'b1), .STAGES(2)) u_dut_c (
        .clk(clk), .async_reset_i(in_c), .sync_reset_o(out_c));
    reset_synchroniser #(.INPUT_POLARITY(1'b0), .OUTPUT_POLARITY(1'b1), .STAGES(2)) u_dut_d (
        .clk(clk), .async_reset_i(in_d), .sync_reset_o(out_d));
    reset_synchroniser #(.INPUT_POLARITY(1'b0), .OUTPUT_POLARITY(1'b1), .STAGES(2)) u_dut_e (
        .clk(clk), .async_reset_i(in_e), .sync_reset_o(out_e));
    // f, g: active-high in, active-low out
    reset_synchroniser #(.INPUT_POLARITY(1'b1), .OUTPUT_POLARITY(1'b0), .STAGES(2)) u_dut_f (
        .clk(clk), .async_reset_i(in_f), .sync_reset_o(out_f));
    reset_synchroniser #(.INPUT_POLARITY(1'b1), .OUTPUT_POLARITY(1'b0), .STAGES(4)) u_dut_g (
        .clk(clk), .async_reset_i(in_g), .sync_reset_o(out_g));

    task automatic wait_until(input realtime t);
        if (t > $realtime) #(t - $realtime);
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    initial begin
        in_a = 1'b1; in_b = 1'b1; in_c = 1'b1; in_d = 1'b1;
        in_e = 1'b0; in_f = 1'b1; in_g = 1'b1;

        wait_until(3);
        check("a_powerup", out_a, 1'b1);
        check("e_held", out_e, 1'b1);
        check("f_held", out_f, 1'b0);
        check("g_held", out_g, 1'b0);

        wait_until(10);
        in_b = 1'b0;
        wait_until(11);
        check("b_assert_immediate", out_b, 1'b1);

        wait_until(14);
        check("a_before_2nd_edge", out_a, 1'b1);
        wait_until(16);
        check("a_released", out_a, 1'b0);

        wait_until(20);
        in_b = 1'b0 ^ 1'b1;
        in_e = 1'b1;
        in_f = 1'b0;
        in_g = 1'b0;

        wait_until(26);
        check("b_one_edge", out_b, 1'b1);
        check("e_one_edge", out_e, 1'b1);
        wait_until(27);
        in_e = 1'b0;
        wait_until(28);
        check("e_reassert", out_e, 1'b1);
        wait_until(29);
        in_e = 1'b1;
        wait_until(30);
        check("e_after_pulse", out_e, 1'b1);
        check("a_stays_low", out_a, 1'b0);

        wait_until(34);
        check("b_before_release", out_b, 1'b1);
        check("f_before_release", out_f, 1'b0);
        wait_until(36);
        check("b_released", out_b, 1'b0);
        check("f_released", out_f, 1'b1);
        check("e_count_restarted", out_e, 1'b1);

        wait_until(39);
        check("c_idle", out_c, 1'b0);
        wait_until(40);
        in_c = 1'b0;
        wait_until(40.5);
        check("c_assert_immediate", out_c, 1'b1);

        wait_until(44);
        check("e_before_release", out_e, 1'b1);
        wait_until(46);
        check("e_released", out_e, 1'b0);

        wait_until(51);
        check("d_idle", out_d, 1'b0);
        wait_until(52);
        in_d = 1'b0;
        wait_until(52.5);
        check("d_glitch_assert", out_d, 1'b1);
        wait_until(53);
        in_d = 1'b1;
        wait_until(54);
        check("d_glitch_held", out_d, 1'b1);
        check("g_before_4th_edge", out_g, 1'b0);
        wait_until(56);
        check("g_released", out_g, 1'b1);

        wait_until(64);
        check("d_before_release", out_d, 1'b1);
        wait_until(66);
        check("d_released", out_d, 1'b0);

        wait_until(99);
        check("c_held_through_clk", out_c, 1'b1);
        wait_until(100);
        in_c = 1'b1;
        wait_until(106);
        check("c_one_edge", out_c, 1'b1);
        wait_until(114);
        check("c_before_release", out_c, 1'b1);
        wait_until(116);
        check("c_released", out_c, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
